// File: rtl/tdes_pkg.sv
// tdes_pkg: shared FSM states, direction/pass constants and the TDES pass schedule
package tdes_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, RELEASE, RESP} state_t;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;
  localparam logic [1:0] PASS_LAST = 2'd2;
  typedef struct packed {
    logic [1:0] key_idx;
    logic       dir;
  } pass_cfg_t;
  // EDE: passes alternate direction starting from the request direction;
  // the middle pass always uses K2, the outer passes swap K1/K3 for decrypt.
  function automatic pass_cfg_t pass_cfg(input logic dec, input logic [1:0] pass);
    pass_cfg_t c;
    c.dir = dec ^ pass[0];
    c.key_idx = pass[0] ? 2'd2 : ((dec ^ pass[1]) ? 2'd3 : 2'd1);
    return c;
  endfunction
endpackage

// File: rtl/tdes_pass_select.sv
// tdes_pass_select: maps (direction, pass) to the key and engine direction for that pass
// Ports: dec/pass select the schedule step; k1..k3 are the captured keys;
// key is the key for the pass; dir is 1 for a DES decrypt pass.
module tdes_pass_select
  import tdes_pkg::*;
(
  input  logic        dec,
  input  logic [1:0]  pass,
  input  logic [63:0] k1,
  input  logic [63:0] k2,
  input  logic [63:0] k3,
  output logic [63:0] key,
  output logic        dir
);
  pass_cfg_t c;
  assign c = pass_cfg(dec, pass);
  assign key = c.key_idx == 2'd1 ? k1 : c.key_idx == 2'd2 ? k2 : k3;
  assign dir = c.dir;
endmodule

// File: rtl/tdes_sequencer.sv
// tdes_sequencer: runs one iterative DES engine three times per request (TDES EDE)
// Ports: req_* request handshake with keys/data/direction; resp_* response handshake;
// err sticky protocol error; core_* drive and observe the external single-DES engine.
module tdes_sequencer
  import tdes_pkg::*;
#(
  parameter bit TWO_KEY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_decrypt,
  input  logic [63:0] req_key1,
  input  logic [63:0] req_key2,
  input  logic [63:0] req_key3,
  input  logic [63:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        err,
  output logic        core_start_encrypt,
  output logic        core_start_decrypt,
  output logic [63:0] core_key,
  output logic [63:0] core_text,
  input  logic        core_done_encrypt,
  input  logic        core_done_decrypt,
  input  logic [63:0] core_text_out
);
  state_t state, state_n;
  logic [63:0] k1_q, k2_q, k3_q, blk_q;
  logic dec_q, dir, exp_done, bad_done, drained;
  logic [1:0] pass_q;
  tdes_pass_select u_sel (
    .dec (dec_q),
    .pass(pass_q),
    .k1  (k1_q),
    .k2  (k2_q),
    .k3  (k3_q),
    .key (core_key),
    .dir (dir)
  );
  assign exp_done = dir ? core_done_decrypt : core_done_encrypt;
  assign bad_done = dir ? core_done_encrypt : core_done_decrypt;
  assign drained = !core_done_encrypt && !core_done_decrypt;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_data = blk_q;
  assign core_text = blk_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = req_valid ? LAUNCH : IDLE;
      LAUNCH:    state_n = WAIT_DONE;
      WAIT_DONE: state_n = (exp_done || bad_done) ? RELEASE : WAIT_DONE;
      RELEASE:   state_n = !drained ? RELEASE : pass_q == PASS_LAST ? RESP : LAUNCH;
      RESP:      state_n = resp_ready ? IDLE : RESP;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k1_q <= '0;
      k2_q <= '0;
      k3_q <= '0;
      blk_q <= '0;
      dec_q <= MODE_ENC;
      pass_q <= '0;
      err <= 1'b0;
      core_start_encrypt <= 1'b0;
      core_start_decrypt <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        k1_q <= req_key1;
        k2_q <= req_key2;
        k3_q <= TWO_KEY ? req_key1 : req_key3;
        blk_q <= req_data;
        dec_q <= req_decrypt;
        pass_q <= '0;
      end
      if (state == LAUNCH) begin
        core_start_encrypt <= dir == MODE_ENC;
        core_start_decrypt <= dir == MODE_DEC;
      end
      // A wrong-direction done still closes the pass, leaving the block untouched.
      if (state == WAIT_DONE && (exp_done || bad_done)) begin
        core_start_encrypt <= 1'b0;
        core_start_decrypt <= 1'b0;
        if (exp_done) blk_q <= core_text_out;
        else err <= 1'b1;
      end
      if (state == RELEASE && drained && pass_q != PASS_LAST) pass_q <= pass_q + 2'd1;
    end
endmodule

// File: tb/tb_tdes_sequencer.sv
// tb_tdes_sequencer: directed checks of the TDES sequencer against a keyed stand-in engine
module tb_tdes_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid[2], req_ready[2], req_decrypt[2], resp_valid[2], resp_ready[2], err[2];
  logic [63:0] key1[2], key2[2], key3[2], req_data[2], resp_data[2];
  logic start_e[2], start_d[2], done_e[2], done_d[2], swap[2];
  logic [63:0] core_key[2], core_text[2], tout[2];
  logic [63:0] key_log[2][4];
  logic dir_log[2][4];
  logic [1:0] pcount[2];
  logic [4:0] cnt[2];
  logic [1:0] drain[2];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  tdes_sequencer #(.TWO_KEY(1'b0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_decrypt(req_decrypt[0]), .req_key1(key1[0]), .req_key2(key2[0]), .req_key3(key3[0]),
    .req_data(req_data[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .err(err[0]), .core_start_encrypt(start_e[0]),
    .core_start_decrypt(start_d[0]), .core_key(core_key[0]), .core_text(core_text[0]),
    .core_done_encrypt(done_e[0]), .core_done_decrypt(done_d[0]), .core_text_out(tout[0])
  );
  tdes_sequencer #(.TWO_KEY(1'b1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_decrypt(req_decrypt[1]), .req_key1(key1[1]), .req_key2(key2[1]), .req_key3(key3[1]),
    .req_data(req_data[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .err(err[1]), .core_start_encrypt(start_e[1]),
    .core_start_decrypt(start_d[1]), .core_key(core_key[1]), .core_text(core_text[1]),
    .core_done_encrypt(done_e[1]), .core_done_decrypt(done_d[1]), .core_text_out(tout[1])
  );

  // Stand-in single-block cipher: E = rotl8 then xor key, D is its inverse.
  function automatic logic [63:0] e1(input logic [63:0] k, input logic [63:0] x);
    return {x[55:0], x[63:56]} ^ k;
  endfunction
  function automatic logic [63:0] d1(input logic [63:0] k, input logic [63:0] x);
    logic [63:0] y;
    y = x ^ k;
    return {y[7:0], y[63:8]};
  endfunction
  function automatic logic [63:0] tdes(input logic dec, input logic [63:0] k1, input logic [63:0] k2,
                                       input logic [63:0] k3, input logic [63:0] x);
    return dec ? d1(k1, e1(k2, d1(k3, x))) : e1(k3, d1(k2, e1(k1, x)));
  endfunction

  // Engine model: done 20 cycles after start rises, cleared two cycles after start drops.
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        cnt[g] <= '0;
        drain[g] <= '0;
        done_e[g] <= 1'b0;
        done_d[g] <= 1'b0;
        tout[g] <= '0;
        pcount[g] <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (req_valid[g] && req_ready[g]) pcount[g] <= '0;
        if (start_e[g] || start_d[g]) begin
          drain[g] <= '0;
          if (!done_e[g] && !done_d[g]) begin
            cnt[g] <= cnt[g] + 5'd1;
            if (cnt[g] == 5'd19) begin
              done_d[g] <= start_d[g] ^ swap[g];
              done_e[g] <= !(start_d[g] ^ swap[g]);
              tout[g] <= start_d[g] ? d1(core_key[g], core_text[g]) : e1(core_key[g], core_text[g]);
              key_log[g][pcount[g]] <= core_key[g];
              dir_log[g][pcount[g]] <= start_d[g];
              pcount[g] <= pcount[g] + 2'd1;
            end
          end
        end else begin
          cnt[g] <= '0;
          if (done_e[g] || done_d[g]) begin
            drain[g] <= drain[g] + 2'd1;
            if (drain[g] == 2'd1) begin
              done_e[g] <= 1'b0;
              done_d[g] <= 1'b0;
              drain[g] <= '0;
            end
          end
        end
      end
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int u, input logic dec, input logic [63:0] k1, input logic [63:0] k2,
                       input logic [63:0] k3, input logic [63:0] x);
    req_decrypt[u] = dec;
    key1[u] = k1;
    key2[u] = k2;
    key3[u] = k3;
    req_data[u] = x;
  endtask

  task automatic wait_resp(input int u);
    int n;
    n = 0;
    while (!resp_valid[u] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_timeout", 64'(n < 100), 64'd1);
  endtask

  task automatic run(input int u, input logic dec, input logic [63:0] k1, input logic [63:0] k2,
                     input logic [63:0] k3, input logic [63:0] x, output logic [63:0] res);
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready[u]), 64'd1);
    drive(u, dec, k1, k2, k3, x);
    req_valid[u] = 1'b1;
    @(negedge clk);
    req_valid[u] = 1'b0;
    chk("req_ready_busy", 64'(req_ready[u]), 64'd0);
    wait_resp(u);
    res = resp_data[u];
    resp_ready[u] = 1'b1;
    @(negedge clk);
    resp_ready[u] = 1'b0;
    chk("resp_drop", 64'(resp_valid[u]), 64'd0);
    chk("ready_back", 64'(req_ready[u]), 64'd1);
  endtask

  task automatic chk_reset(input int u);
    chk("rst_req_ready", 64'(req_ready[u]), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid[u]), 64'd0);
    chk("rst_err", 64'(err[u]), 64'd0);
    chk("rst_starts", 64'({start_e[u], start_d[u]}), 64'd0);
    chk("rst_core_key", core_key[u], 64'd0);
    chk("rst_core_text", core_text[u], 64'd0);
    chk("rst_resp_data", resp_data[u], 64'd0);
  endtask

  initial begin
    logic [63:0] kd, ka, kb, kc, x, y, r, r2;
    int n, bad;
    kd = 64'h133457799BBCDFF1;
    ka = 64'h0123456789ABCDEF;
    kb = 64'h23456789ABCDEF01;
    kc = 64'h456789ABCDEF0123;
    x = 64'h5468652071756663;
    y = 64'hA5A5_0F0F_1234_5678;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      resp_ready[u] = 1'b0;
      swap[u] = 1'b0;
      drive(u, 1'b0, '0, '0, '0, '0);
    end
    repeat (3) @(negedge clk);
    chk_reset(0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset(1);

    run(0, 1'b0, kd, kd, kd, 64'h0123456789ABCDEF, r);
    chk("deg_enc", r, 64'h307130F0307130F0);
    run(0, 1'b1, kd, kd, kd, r, r2);
    chk("deg_dec", r2, 64'h0123456789ABCDEF);

    run(0, 1'b0, ka, kb, kc, x, r);
    chk("rt_enc", r, tdes(1'b0, ka, kb, kc, x));
    chk("enc_keys", {key_log[0][0] ^ ka, key_log[0][1] ^ kb}, 64'd0);
    chk("enc_key3", key_log[0][2], kc);
    chk("enc_dirs", 64'({dir_log[0][0], dir_log[0][1], dir_log[0][2]}), 64'b010);
    run(0, 1'b1, ka, kb, kc, r, r2);
    chk("rt_dec", r2, x);
    chk("dec_key1", key_log[0][0], kc);
    chk("dec_key3", key_log[0][2], ka);
    chk("dec_dirs", 64'({dir_log[0][0], dir_log[0][1], dir_log[0][2]}), 64'b101);
    chk("rt_err", 64'(err[0]), 64'd0);

    run(1, 1'b0, ka, kb, 64'hFFFFFFFFFFFFFFFF, x, r);
    chk("two_key_pass2", key_log[1][2], ka);
    run(1, 1'b0, ka, kb, ka, x, r2);
    chk("two_key_same", r, r2);
    chk("two_key_val", r, tdes(1'b0, ka, kb, ka, x));

    @(negedge clk);
    drive(0, 1'b0, ka, kb, kc, x);
    req_valid[0] = 1'b1;
    @(negedge clk);
    wait_resp(0);
    r = resp_data[0];
    chk("bp_first", r, tdes(1'b0, ka, kb, kc, x));
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[0] || !resp_valid[0] || resp_data[0] !== r) bad++;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    resp_ready[0] = 1'b1;
    req_data[0] = y;
    @(negedge clk);
    resp_ready[0] = 1'b0;
    chk("bp_single", 64'(resp_valid[0]), 64'd0);
    chk("bp_idle", 64'(req_ready[0]), 64'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("bp_next_accept", 64'(req_ready[0]), 64'd0);
    wait_resp(0);
    chk("bp_second", resp_data[0], tdes(1'b0, ka, kb, kc, y));
    resp_ready[0] = 1'b1;
    @(negedge clk);
    resp_ready[0] = 1'b0;

    drive(0, 1'b0, ka, kb, kc, x);
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!start_d[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_pass1", 64'(n < 100), 64'd1);
    #2 rst = 1'b1;
    #1 chk_reset(0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 1'b0, ka, kb, kc, y, r);
    chk("after_rst", r, tdes(1'b0, ka, kb, kc, y));

    swap[0] = 1'b1;
    run(0, 1'b0, ka, kb, kc, x, r);
    chk("bad_done_err", 64'(err[0]), 64'd1);
    chk("bad_done_blk", r, x);
    swap[0] = 1'b0;
    run(0, 1'b0, ka, kb, kc, x, r);
    chk("err_sticky", 64'(err[0]), 64'd1);
    chk("after_err", r, tdes(1'b0, ka, kb, kc, x));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdes_sequencer.md
# tdes_sequencer

Triple-DES (EDE) sequencer that runs one iterative DES engine (`Control_State_Machine`) three times per request. It accepts a 64-bit block and three 64-bit keys over a valid/ready handshake. For each pass it drives the engine's start, key and text inputs, chains the intermediate result into the next pass, and returns the final block over a valid/ready response handshake. It sits between the host/bus interface and the single-DES engine, which it owns exclusively.

## Interface
- `TWO_KEY`, default 0: when 1, K3 is forced equal to K1 (keying option 2); `req_key3` is ignored.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_decrypt` in 1: 0 selects TDES encrypt (E-D-E), 1 selects TDES decrypt (D-E-D).
- `req_key1`, `req_key2`, `req_key3` in 64 each: DES keys, with parity bits included.
- `req_data` in 64: input block.
- `resp_valid` out 1: result present.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out 64: output block.
- `err` out 1: sticky protocol error. Cleared only by `rst`.
- `core_start_encrypt`, `core_start_decrypt` out 1 each: level starts to the engine.
- `core_key` out 64: key for the current pass.
- `core_text` out 64: input block for the current pass.
- `core_done_encrypt`, `core_done_decrypt` in 1 each: engine completion levels.
- `core_text_out` in 64: engine result.

## Operation
- Request capture: the request is accepted when `req_valid && req_ready`. On acceptance the sequencer registers:
  - the three keys into `k1_q`, `k2_q`, `k3_q`; `k3_q = k1` when `TWO_KEY = 1`.
  - `req_data` into `blk_q`.
  - the direction into `dec_q`.
- `pass_q` (2 bits) counts 0, 1, 2.
- Pass schedule for encrypt: pass 0 uses K1 and E; pass 1 uses K2 and D; pass 2 uses K3 and E.
- Pass schedule for decrypt: pass 0 uses K3 and D; pass 1 uses K2 and E; pass 2 uses K1 and D.
- `core_key` and `core_text = blk_q` are driven from registers. They stay stable from the start assertion until the matching done is observed.
- States:
  - IDLE: `req_ready = 1`. On accept, go to LAUNCH with `pass_q = 0`.
  - LAUNCH: go to WAIT_DONE after one cycle. The start line for the pass direction rises registered and is held through WAIT_DONE. Exactly one start line is high at a time.
  - WAIT_DONE: on the expected done, set `blk_q <= core_text_out`, drop start, go to RELEASE.
  - RELEASE: start lines low. Wait until both done inputs are 0. Then, if `pass_q == 2`, go to RESP; otherwise increment `pass_q` and go to LAUNCH.
  - RESP: `resp_valid = 1`, `resp_data = blk_q`. On `resp_ready`, go to IDLE.
- Unexpected done (the done for the opposite direction, while in WAIT_DONE):
  - set `err`, drop start, go to RELEASE;
  - the pass is treated as complete with `blk_q` unchanged.
- A done seen in IDLE, LAUNCH or RESP is ignored and does not set `err`.
- `req_ready` is 0 in every state except IDLE. A new request is never overlapped with an in-flight one.

## Timing
- Reset values:
  - `req_ready` = 1;
  - `resp_valid`, `err`, `core_start_*` = 0;
  - `resp_data`, `core_key`, `core_text` = 0;
  - state = IDLE, `pass_q` = 0.
- Reset mid-operation aborts immediately. Start lines fall asynchronously with `rst`. The engine shares `rst`.
- Per-pass engine latency: done is high 20 cycles after start first rises.
- Sequencer overhead per pass: 1 cycle in LAUNCH, 1 cycle to drop start, and the engine's 2-cycle DONE→IDLE→done-clear drain in RELEASE.
- Nominal per-pass time: 24 cycles.
- Nominal request latency: accept to `resp_valid` of 73 cycles. The bench must not rely on this exact figure; it uses a 100-cycle timeout.
- `resp_valid` holds with `resp_data` stable until `resp_ready`. A response back-pressured indefinitely stalls the block with no data loss.
- `req_ready` rises in the cycle after the response handshake completes. Back-to-back requests therefore have a minimum 1-cycle IDLE gap.
- `req_valid` and `resp_ready` may be high at the same time.

## Structure
- Shared package `tdes_pkg` holds:
  - state enum (IDLE, LAUNCH, WAIT_DONE, RELEASE, RESP);
  - `MODE_ENC = 1'b0`, `MODE_DEC = 1'b1`;
  - `PASS_LAST = 2'd2`;
  - a function returning the key index and direction for a given (`dec`, `pass`).
- One combinational sub-module, `tdes_pass_select`, maps (`dec_q`, `pass_q`, `k1_q`, `k2_q`, `k3_q`) to `core_key` and the pass direction. The FSM and registers stay in `tdes_sequencer`.
- The DES engine is instantiated outside this block, in the top level, and connected only through the `core_*` ports.

## Test plan
- Degenerate single DES: all keys `133457799BBCDFF1`, encrypt `0123456789ABCDEF` → `resp_data = 85E813540F0AB405`. Decrypt of that value → `0123456789ABCDEF`.
- Round trip with three distinct keys `0123456789ABCDEF`, `23456789ABCDEF01`, `456789ABCDEF0123`: encrypt `5468652071756663`, decrypt the result → `5468652071756663`. `err` stays 0.
- `TWO_KEY = 1`: `req_key3 = FFFFFFFFFFFFFFFF` (garbage) gives the same result as `req_key3 = req_key1`. Monitor that `core_key` equals K1 on pass 2.
- Back-pressure: hold `resp_ready = 0` for 50 cycles with `req_valid = 1` → `req_ready` stays 0 and `resp_data` stays stable. Release → exactly one response, then the next request is accepted.
- Rst mid-pass, at pass 1 in WAIT_DONE → all outputs return to reset values immediately. A fresh request afterwards completes correctly.
- Engine model returns `core_done_decrypt` when encrypt is expected → `err = 1` (sticky). The response is still delivered, and `req_ready` returns to 1.
